// File: rtl/vga_timing_480_if.sv
// ============================================================================
// vga_timing_480_if : timing outputs (syncs, data enable, pixel coordinates)
// Rev 1.0
// ============================================================================
`default_nettype none

interface vga_timing_480_if;
  logic       o_hsync;
  logic       o_vsync;
  logic       o_de;
  logic [9:0] o_Sx;
  logic [9:0] o_Sy;

  modport master (output o_hsync, o_vsync, o_de, o_Sx, o_Sy);
  modport slave  (input  o_hsync, o_vsync, o_de, o_Sx, o_Sy);
endinterface

`default_nettype wire

// File: rtl/vga_timing_480.sv
// ============================================================================
// vga_timing_480 : free-running 640x480@60 VGA timing generator
// Rev 1.0
// ============================================================================
`default_nettype none

module vga_timing_480 #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input  wire logic        i_VGA_CLOCK,
  input  wire logic        i_rst,
  vga_timing_480_if.master vga_o
);

  localparam logic [9:0] H_LAST       = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST       = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_SYNC_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_SYNC_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] H_VIS        = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS        = 10'(V_ACTIVE);

  logic [9:0] sx_q;
  logic [9:0] sx_d;
  logic [9:0] sy_q;
  logic [9:0] sy_d;
  logic       hsync_on;
  logic       vsync_on;

  always_comb begin
    sx_d = sx_q + 10'd1;
    sy_d = sy_q;
    if (sx_q == H_LAST) begin
      sx_d = '0;
      sy_d = (sy_q == V_LAST) ? '0 : sy_q + 10'd1;
    end
  end

  always_ff @(posedge i_VGA_CLOCK or posedge i_rst) begin
    if (i_rst) begin
      sx_q <= '0;
      sy_q <= '0;
    end else begin
      sx_q <= sx_d;
      sy_q <= sy_d;
    end
  end

  // Decodes read the counter registers directly so they align with o_Sx/o_Sy.
  assign hsync_on = (sx_q >= H_SYNC_FIRST) && (sx_q <= H_SYNC_LAST);
  assign vsync_on = (sy_q >= V_SYNC_FIRST) && (sy_q <= V_SYNC_LAST);

  assign vga_o.o_Sx    = sx_q;
  assign vga_o.o_Sy    = sy_q;
  assign vga_o.o_hsync = hsync_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign vga_o.o_vsync = vsync_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  // Reset gates DE so the (0,0) counters held in reset do not look visible.
  assign vga_o.o_de    = ~i_rst && (sx_q < H_VIS) && (sy_q < V_VIS);

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_480.sv
// Bench for vga_timing_480: full-size instance for horizontal timing and a
// scoreboard, reduced-geometry instance for whole-frame behaviour.
`timescale 1ns/1ps
`default_nettype none

module tb_vga_timing_480;

  localparam int CLK_HALF = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   sb_cmp = 0;

  vga_timing_480_if vif ();
  vga_timing_480_if vif_s ();

  vga_timing_480 dut (
    .i_VGA_CLOCK (clk),
    .i_rst       (rst),
    .vga_o       (vif)
  );

  // 32 x 15 geometry: 480-clock frames keep whole-frame checks short.
  vga_timing_480 #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(8),  .V_FP(2), .V_SYNC(2), .V_BP(3),
    .SYNC_ACTIVE(1'b0)
  ) dut_s (
    .i_VGA_CLOCK (clk),
    .i_rst       (rst),
    .vga_o       (vif_s)
  );

  always #CLK_HALF clk = ~clk;

  typedef struct packed {
    logic [9:0] sx;
    logic [9:0] sy;
    logic       hs;
    logic       vs;
    logic       de;
  } vrec_t;

  typedef struct {
    int   adv;
    int   sx;
    int   sy;
    logic hs;
    logic vs;
    logic de;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vrec_t ref_out(input int sx, input int sy, input logic r);
    vrec_t e;
    e.sx = 10'(sx);
    e.sy = 10'(sy);
    e.hs = !(sx >= 656 && sx <= 751);
    e.vs = !(sy >= 490 && sy <= 491);
    e.de = !r && (sx < 640) && (sy < 480);
    return e;
  endfunction

  // Scoreboard: reference position advances on each edge, expectation queued;
  // the falling edge pops and compares against the full-size instance.
  vrec_t sb_q[$];
  int    m_sx = 0;
  int    m_sy = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_sx = 0;
      m_sy = 0;
      sb_q.delete();
    end else begin
      m_sx = m_sx + 1;
      if (m_sx == 800) begin
        m_sx = 0;
        m_sy = (m_sy + 1) % 525;
      end
    end
    sb_q.push_back(ref_out(m_sx, m_sy, rst));
  end

  always @(negedge clk) begin : sb_consumer
    vrec_t e;
    vrec_t a;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      a.sx = vif.o_Sx;
      a.sy = vif.o_Sy;
      a.hs = vif.o_hsync;
      a.vs = vif.o_vsync;
      a.de = vif.o_de;
      total++;
      sb_cmp++;
      if (a !== e) begin
        bad++;
        $display("FAIL scoreboard: got sx=%0d sy=%0d hs=%b vs=%b de=%b, expected sx=%0d sy=%0d hs=%b vs=%b de=%b",
                 a.sx, a.sy, a.hs, a.vs, a.de, e.sx, e.sy, e.hs, e.vs, e.de);
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sx"}, int'(vif.o_Sx), 0);
    chk({tag, "_sy"}, int'(vif.o_Sy), 0);
    chk({tag, "_de"}, int'(vif.o_de), 0);
    chk({tag, "_hs"}, int'(vif.o_hsync), 1);
    chk({tag, "_vs"}, int'(vif.o_vsync), 1);
    chk({tag, "_s_de"}, int'(vif_s.o_de), 0);
  endtask

  vec_t tbl [11];

  initial begin
    int h_fall[$];
    int h_rise[$];
    int s_vfall[$];
    int prev_hs, prev_shs, prev_svs, prev_ssx, prev_ssy;
    int s_max_sx, s_max_sy, s_de, s_hfall, s_vlow, s_wrap;
    int d0, d1;

    //            adv  sx   sy  hs    vs    de
    tbl[0]  = '{  1,   1,   0, 1'b1, 1'b1, 1'b1};
    tbl[1]  = '{638, 639,   0, 1'b1, 1'b1, 1'b1};
    tbl[2]  = '{  1, 640,   0, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{ 15, 655,   0, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{  1, 656,   0, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{ 95, 751,   0, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{  1, 752,   0, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{ 47, 799,   0, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{  1,   0,   1, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{800,   0,   2, 1'b1, 1'b1, 1'b1};
    tbl[10] = '{656, 656,   2, 1'b0, 1'b1, 1'b0};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    chk_reset_vals("rst");

    @(negedge clk);
    #1 rst = 1'b0;
    #2;
    chk("rel_sx", int'(vif.o_Sx), 0);
    chk("rel_de", int'(vif.o_de), 1);

    foreach (tbl[i]) begin
      repeat (tbl[i].adv) @(negedge clk);
      chk($sformatf("vec%0d_sx", i), int'(vif.o_Sx), tbl[i].sx);
      chk($sformatf("vec%0d_sy", i), int'(vif.o_Sy), tbl[i].sy);
      chk($sformatf("vec%0d_hs", i), int'(vif.o_hsync), int'(tbl[i].hs));
      chk($sformatf("vec%0d_vs", i), int'(vif.o_vsync), int'(tbl[i].vs));
      chk($sformatf("vec%0d_de", i), int'(vif.o_de), int'(tbl[i].de));
    end

    // Move to (300,3) and reset asynchronously between clock edges.
    repeat (444) @(negedge clk);
    chk("mid_pre_sx", int'(vif.o_Sx), 300);
    chk("mid_pre_sy", int'(vif.o_Sy), 3);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk_reset_vals("mid_rst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    #2;
    chk("restart_sx", int'(vif.o_Sx), 0);
    chk("restart_sy", int'(vif.o_Sy), 0);
    chk("restart_de", int'(vif.o_de), 1);

    prev_hs = 1; prev_shs = 1; prev_svs = 1; prev_ssx = -1; prev_ssy = -1;
    s_max_sx = 0; s_max_sy = 0; s_de = 0; s_hfall = 0; s_vlow = 0; s_wrap = 0;
    for (int i = 0; i < 1600; i++) begin
      if (prev_hs == 1 && vif.o_hsync == 1'b0) h_fall.push_back(i);
      if (prev_hs == 0 && vif.o_hsync == 1'b1) h_rise.push_back(i);
      prev_hs = int'(vif.o_hsync);
      if (i < 960) begin
        if (int'(vif_s.o_Sx) > s_max_sx) s_max_sx = int'(vif_s.o_Sx);
        if (int'(vif_s.o_Sy) > s_max_sy) s_max_sy = int'(vif_s.o_Sy);
        if (vif_s.o_de) s_de++;
        if (!vif_s.o_vsync) s_vlow++;
        if (prev_shs == 1 && vif_s.o_hsync == 1'b0) s_hfall++;
        if (prev_svs == 1 && vif_s.o_vsync == 1'b0) s_vfall.push_back(i);
        if (prev_ssx == 31 && prev_ssy == 14) begin
          s_wrap++;
          chk("s_frame_wrap_sx", int'(vif_s.o_Sx), 0);
          chk("s_frame_wrap_sy", int'(vif_s.o_Sy), 0);
        end
        if (vif_s.o_Sx == 10'd31 && vif_s.o_Sy == 10'd14)
          chk("s_de_last", int'(vif_s.o_de), 0);
        prev_shs = int'(vif_s.o_hsync);
        prev_svs = int'(vif_s.o_vsync);
        prev_ssx = int'(vif_s.o_Sx);
        prev_ssy = int'(vif_s.o_Sy);
      end
      @(negedge clk);
    end

    chk("h_fall_count", h_fall.size(), 2);
    d0 = (h_fall.size() > 0) ? h_fall[0] : -1;
    chk("h_fall_first", d0, 656);
    d1 = (h_rise.size() > 0 && h_fall.size() > 0) ? h_rise[0] - h_fall[0] : -1;
    chk("h_pulse_width", d1, 96);
    d1 = (h_fall.size() > 1) ? h_fall[1] - h_fall[0] : -1;
    chk("h_period", d1, 800);

    chk("s_max_sx", s_max_sx, 31);
    chk("s_max_sy", s_max_sy, 14);
    chk("s_de_count", s_de, 256);
    chk("s_hsync_pulses", s_hfall, 30);
    chk("s_vsync_pulses", s_vfall.size(), 2);
    chk("s_vsync_low", s_vlow, 128);
    d0 = (s_vfall.size() > 0) ? s_vfall[0] : -1;
    chk("s_vsync_first", d0, 320);
    d1 = (s_vfall.size() > 1) ? s_vfall[1] - s_vfall[0] : -1;
    chk("s_frame_period", d1, 480);
    chk("s_wraps", s_wrap, 1);
    chk("sb_activity", int'(sb_cmp > 1000), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vga_timing_480.md
Name: vga_timing_480

Overview:
- Free-running VGA timing generator for 640x480 @ 60 Hz, driven by a 25.175 MHz pixel clock.
- Produces horizontal sync, vertical sync, data-enable, and the current pixel coordinates (Sx, Sy).
- Sits between the pixel clock source and the pixel/colour pipeline, which uses Sx/Sy/o_de to generate RGB.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_ACTIVE, 0, logic level of an asserted sync pulse (0 = negative polarity)

Ports:
- i_VGA_CLOCK  in  1  pixel clock, 25.175 MHz nominal, rising-edge
- i_rst  in  1  asynchronous, active-high reset
- o_hsync  out  1  horizontal sync
- o_vsync  out  1  vertical sync
- o_de  out  1  data enable; high only in the visible area
- o_Sx  out  10  horizontal pixel counter, 0..799
- o_Sy  out  10  vertical line counter, 0..524

Behaviour:
- Interface: one clock (i_VGA_CLOCK); reset i_rst is asynchronous and active-high.
- Derived totals: H_TOTAL = 640+16+96+48 = 800; V_TOTAL = 480+10+2+33 = 525.
- Reset: while i_rst is high, the outputs are held at these values, applied immediately and independent of the clock:
  - o_Sx = 0, o_Sy = 0
  - o_de = 0
  - o_hsync = o_vsync = !SYNC_ACTIVE (deasserted)
- Counting, on each rising edge with i_rst low:
  - Sx increments by 1.
  - When Sx = H_TOTAL-1, Sx wraps to 0 and Sy increments.
  - When Sx = H_TOTAL-1 and Sy = V_TOTAL-1, both wrap to 0 (end of frame).
- o_Sx and o_Sy are the counter registers; counter width is fixed at 10 bits.
- Decodes: combinational from the current counter registers, zero latency relative to o_Sx/o_Sy.
  - o_hsync = SYNC_ACTIVE when 656 <= Sx <= 751 (H_ACTIVE+H_FP .. H_ACTIVE+H_FP+H_SYNC-1); otherwise !SYNC_ACTIVE.
  - o_vsync = SYNC_ACTIVE when 490 <= Sy <= 491; otherwise !SYNC_ACTIVE. It is purely a function of Sy, so it is asserted for whole lines (2 x 800 = 1600 clocks).
  - o_de = 1 when Sx < 640 and Sy < 480 and i_rst is low; otherwise 0.
- First cycle after reset release: Sx = 0, Sy = 0, o_de = 1. The first rising edge with i_rst low advances Sx to 1.
- Reset asserted mid-frame: counters clear immediately; counting restarts from (0,0) after release; no partial-state carry-over.
- Resulting timing at 25.175 MHz:
  - line period 800 clocks, 31.47 kHz
  - hsync pulse 96 clocks, about 3.81 us
  - frame period 420000 clocks, 59.94 Hz
  - vsync pulse 1600 clocks, about 63.55 us
- Sx never exceeds 799 and Sy never exceeds 524; no other states exist.

Test Plan:
1. Reset then release:
   - While i_rst = 1, required: Sx = 0, Sy = 0, o_de = 0, o_hsync = 1, o_vsync = 1.
   - After release, required: o_de = 1 at Sx = 0, and Sx = 1 after the first edge.
2. Horizontal timing:
   - o_hsync falls when Sx becomes 656 and rises when Sx becomes 752 (96 clocks low).
   - Falling-edge to falling-edge period is 800 clocks.
   - Sx wraps 799 -> 0 and Sy increments on the same edge.
3. Vertical timing:
   - o_vsync is low exactly while Sy is 490 or 491 (1600 clocks).
   - Falling-edge to falling-edge period is 420000 clocks.
   - At Sx = 799, Sy = 524, the next edge gives Sx = 0, Sy = 0.
4. Data enable:
   - Over one frame, o_de is high for exactly 640 x 480 = 307200 clocks.
   - o_de is low at (640, 0), (0, 480) and (799, 524).
5. Mid-frame reset: assert i_rst asynchronously at Sx = 300, Sy = 200.
   - Required: outputs go to their reset values before the next clock edge.
   - After release, counting restarts from (0,0) with 800-clock lines.
6. Range check over two full frames: max Sx = 799, max Sy = 524; o_hsync and o_vsync pulse counts are 1050 and 2.
